sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//  Asynchronous 16-bit external SRAM controller, directly downstream of the UART control interface.
//  Turns single-cycle rd/wr strobes into timed CE#/OE#/WE# cycles on the SRAM pins.
//  Returns read data with a one-cycle data_valid pulse and a busy flag for back-pressure.
//  Tristate buffer lives in the top level; this block exposes dq_o/dq_oe/dq_i.
// PARAMETERS
//  ADDR_W      16  external address width, >=16; pins above bit 15 driven 0
//  RD_WAIT     3   read access cycles with CE#/OE# low before capture, 1..15
//  WR_WAIT     3   cycles WE# held low, 1..15
//  TURNAROUND  1   idle cycles (all strobes high, dq_oe=0) after every access, 0..15
// PORTS
//  clk         in   1       system clock, 50 MHz
//  rst         in   1       synchronous reset, active-high
//  req         in   1       host owns the SRAM; rd/wr are ignored while low
//  rd          in   1       read strobe, sampled only in IDLE
//  wr          in   1       write strobe, sampled only in IDLE
//  addr        in   16      word address
//  wdata       in   16      write data
//  rdata       out  16      captured read data, held until next read capture
//  busy        out  1       high while an access or turnaround is in progress
//  data_valid  out  1       one-cycle pulse when rdata is updated
//  sram_a      out  ADDR_W  SRAM address pins
//  sram_dq_o   out  16      data to pins
//  sram_dq_oe  out  1       drive enable for sram_dq_o
//  sram_dq_i   in   16      data from pins
//  sram_ce_n / sram_oe_n / sram_we_n  out  1  active-low strobes
//  sram_ub_n / sram_lb_n              out  1  byte lanes, constant 0 (full-word only)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, data_valid=0, rdata=0, sram_a=0, dq_o=0, dq_oe=0, ce_n=oe_n=we_n=1.
//  - Reset mid-access: strobes high and dq_oe=0 on the same edge; the access is abandoned.
//  - Accept: in IDLE with req=1, wr or rd high at edge T -> addr/wdata latched; busy=1 from T+1.
//  - wr and rd high together: write wins; the read is dropped.
//  - rd/wr seen while busy=1 or req=0: dropped and never queued; busy/outputs unchanged.
//  - States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
//  - Read: RD_ACC for T+1..T+RD_WAIT with ce_n=0, oe_n=0, sram_a valid.
//    - On the last RD_ACC edge: rdata<=sram_dq_i; data_valid=1 during cycle T+RD_WAIT+1.
//  - Write: WR_SETUP 1 cycle (ce_n=0, dq_oe=1, we_n=1), then WR_PULSE WR_WAIT cycles (we_n=0),
//    then WR_HOLD 1 cycle (we_n=1; ce_n=0, dq_oe=1, address/data still held).
//  - TURN: TURNAROUND cycles with ce_n=oe_n=we_n=1, dq_oe=0; TURNAROUND=0 goes straight to IDLE.
//  - busy drops in the first IDLE cycle; a new strobe is accepted in that same cycle.
//  - dq_oe is never 1 while oe_n=0.
//  - sram_a, dq_o hold the last access values in IDLE; no glitches while ce_n=0.
//  - Wait counter: 4-bit down-counter, loaded on state entry; no wrap (parameters are bounded).
//  - req falling mid-access does not abort the access; only new strobes are gated.
// CONFIGURATION
//  SRAM_CTRL_DROP_CNT_EN defined:
//    - Adds output drop_cnt [7:0], reset 0.
//    - +1 per cycle in which a rd or wr strobe is dropped (busy, req=0, or read losing to a write).
//    - Saturates at 8'hFF.
//  Undefined: no drop_cnt port; drops are silent. Access timing is identical either way.
// TESTING
//  1. Defaults: wr addr=16'h1234 wdata=16'hBEEF -> we_n low cycles T+2..T+4, dq_o=BEEF, dq_oe=1 T+1..T+5,
//     busy T+1..T+6.
//  2. rd addr=16'h1234 with model returning 16'hBEEF -> oe_n low T+1..T+3; data_valid=1, rdata=BEEF
//     at T+4 only.
//  3. rd strobe at T+2 during a write -> ignored, no oe_n activity; drop_cnt=1 when enabled.
//  4. rd and wr high at once with req=1 -> write cycle only, no data_valid; drop_cnt=1 when enabled.
//  5. req=0 with wr pulse -> ce_n stays 1, busy stays 0.
//  6. rst=1 during WR_PULSE -> next cycle we_n=1, ce_n=1, dq_oe=0, busy=0; a following rd completes
//     normally.

Source files
------------

// File: rtl/sram_ctrl.sv
// Asynchronous 16-bit SRAM controller: rd/wr strobes become timed CE#/OE#/WE# cycles.
// Optional drop counter output enabled by defining SRAM_CTRL_DROP_CNT_EN.
module sram_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_WAIT    = 3,
  parameter int unsigned WR_WAIT    = 3,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rd,
  input  logic              wr,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              data_valid,
  output logic [ADDR_W-1:0] sram_a,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
`ifdef SRAM_CTRL_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TURN_LOAD_I = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_LOAD_I);

  typedef enum logic [2:0] {
    IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, TURN
  } state_t;

  localparam state_t POST_ACC = (TURNAROUND == 0) ? IDLE : TURN;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_rd, accept_wr, capture;
  logic             ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic [15:0]      sram_a_q;

  // Next state, wait counter, and next values of the pin strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && wr) begin
          state_d   = WR_SETUP;
          accept_wr = 1'b1;
        end else if (req && rd) begin
          state_d   = RD_ACC;
          cnt_d     = RD_LOAD;
          accept_rd = 1'b1;
        end
      end
      RD_ACC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = POST_ACC;
          cnt_d   = TURN_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WR_HOLD: begin
        state_d = POST_ACC;
        cnt_d   = TURN_LOAD;
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    ce_n_d  = !(state_d inside {RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD});
    oe_n_d  = (state_d != RD_ACC);
    we_n_d  = (state_d != WR_PULSE);
    dq_oe_d = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
  end

  // Strobes are registered from the next state so the pins change only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      rdata      <= '0;
      sram_a_q   <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= (state_d != IDLE);
      data_valid <= capture;
      sram_dq_oe <= dq_oe_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      if (capture)                sram_a_q  <= sram_a_q;
      if (capture)                rdata     <= sram_dq_i;
      if (accept_rd || accept_wr) sram_a_q  <= addr;
      if (accept_wr)              sram_dq_o <= wdata;
    end
  end

  assign sram_a    = ADDR_W'(sram_a_q);
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

`ifdef SRAM_CTRL_DROP_CNT_EN
  logic drop_c;
  assign drop_c = (rd || wr) && ((state_q != IDLE) || !req || (rd && wr));

  // Saturating count of strobes that were not turned into an access.
  always_ff @(posedge clk) begin
    if (rst)                           drop_cnt <= '0;
    else if (drop_c && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed scenarios then random traffic against a timeline model.
module tb_sram_ctrl;
  localparam int unsigned RD_WAIT    = 3;
  localparam int unsigned WR_WAIT    = 3;
  localparam int unsigned TURNAROUND = 1;
  localparam int RD_LEN = RD_WAIT + TURNAROUND;
  localparam int WR_LEN = WR_WAIT + 2 + TURNAROUND;

  logic        clk = 1'b0;
  logic        rst, req, rd, wr;
  logic [15:0] addr, wdata, rdata, sram_dq_o, sram_dq_i, sram_a;
  logic        busy, data_valid, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_CTRL_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  sram_ctrl #(.ADDR_W(16), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk), .rst(rst), .req(req), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .data_valid(data_valid), .sram_a(sram_a),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
`ifdef SRAM_CTRL_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Small SRAM device model (address aliased to 16 words).
  logic [15:0] mem [16] = '{default: 16'h0000};
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[3:0]] : 16'h0000;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_a[3:0]] <= sram_dq_o;

  // Reference model: access kind (0 none, 1 read, 2 write) and cycle index since acceptance.
  int          kind = 0, k = 0, m_drops = 0;
  logic [15:0] m_a = '0, m_dq = '0, m_rdata = '0;
  logic        m_dv = 1'b0;
  logic [15:0] ref_mem [16] = '{default: 16'h0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic model_edge(input logic r, q, vrd, vwr, input logic [15:0] ad, wd);
    int nk;
    if (kind == 2 && k >= 2 && k <= int'(WR_WAIT) + 1) ref_mem[m_a[3:0]] = m_dq;
    m_dv = 1'b0;
    if (r) begin
      kind = 0; k = 0; m_a = '0; m_dq = '0; m_rdata = '0; m_drops = 0;
    end else if (kind == 0) begin
      if (q && vwr) begin
        kind = 2; k = 1; m_a = ad; m_dq = wd;
        if (vrd) drop();
      end else if (q && vrd) begin
        kind = 1; k = 1; m_a = ad;
      end else if (vrd || vwr) drop();
    end else begin
      if (vrd || vwr) drop();
      nk = k + 1;
      if (kind == 1 && nk == int'(RD_WAIT) + 1) begin
        m_dv = 1'b1; m_rdata = ref_mem[m_a[3:0]];
      end
      if (nk > ((kind == 1) ? RD_LEN : WR_LEN)) begin kind = 0; k = 0; end
      else k = nk;
    end
  endtask

  task automatic check_pins();
    logic e_ce_n, e_oe_n, e_we_n, e_oe;
    e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_oe = 1'b0;
    if (kind == 1 && k <= int'(RD_WAIT)) begin e_ce_n = 1'b0; e_oe_n = 1'b0; end
    if (kind == 2 && k <= int'(WR_WAIT) + 2) begin e_ce_n = 1'b0; e_oe = 1'b1; end
    if (kind == 2 && k >= 2 && k <= int'(WR_WAIT) + 1) e_we_n = 1'b0;
    chk("busy",       32'(busy),       32'(kind != 0));
    chk("ce_n",       32'(sram_ce_n),  32'(e_ce_n));
    chk("oe_n",       32'(sram_oe_n),  32'(e_oe_n));
    chk("we_n",       32'(sram_we_n),  32'(e_we_n));
    chk("dq_oe",      32'(sram_dq_oe), 32'(e_oe));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    chk("rdata",      32'(rdata),      32'(m_rdata));
    chk("sram_a",     32'(sram_a),     32'(m_a));
    chk("dq_o",       32'(sram_dq_o),  32'(m_dq));
    chk("byte_lanes", 32'({sram_ub_n, sram_lb_n}), 32'(0));
`ifdef SRAM_CTRL_DROP_CNT_EN
    chk("drop_cnt",   32'(drop_cnt),   32'(m_drops));
`endif
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic step(input logic r, q, vrd, vwr, input logic [15:0] ad, wd);
    @(negedge clk);
    rst = r; req = q; rd = vrd; wr = vwr; addr = ad; wdata = wd;
    @(posedge clk);
    model_edge(r, q, vrd, vwr, ad, wd);
    #1;
    check_pins();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Write then read back the same word.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'hBEEF);
    idle(7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0);
    idle(3);
    chk("t2_dv", 32'(data_valid), 32'(1));
    chk("t2_rdata", 32'(rdata), 32'(16'hBEEF));
    idle(3);

    // Read strobe during a write is dropped.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h1111);
    idle(1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0);
    idle(6);

    // Simultaneous rd and wr: the write wins.
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0007, 16'h7777);
    idle(7);

    // req low gates a write strobe.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h8888);
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_ce_n", 32'(sram_ce_n), 32'(1));
    idle(2);

    // Reset during WR_PULSE abandons the access; a following read completes.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h5A5A);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("t6_we_n", 32'(sram_we_n), 32'(1));
    chk("t6_ce_n", 32'(sram_ce_n), 32'(1));
    chk("t6_dq_oe", 32'(sram_dq_oe), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           16'($urandom_range(0, 15)), 16'($urandom));
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
